// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port synchronous RAM: a valid/ready command port starts
// read or write bursts of REQ_LEN+1 beats, streamed one beat per cycle.
module ram_burst_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 10,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WR,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [LEN_WIDTH-1:0]  REQ_LEN,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WDATA_VALID,
  output logic                  WDATA_READY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  RDATA_VALID,
  output logic                  DONE,
  output logic                  BUSY,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DIN,
  input  logic [DATA_WIDTH-1:0] RAM_DOUT,
  output logic [1:0]            STATE_DBG
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_DRAIN} state_t;

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_nxt;
  logic                  rd_issued_q;
  logic                  rd_last_q;
  logic                  wr_last;

  // Handshakes: a command (REQ_VALID & REQ_READY) or a write beat (WDATA_VALID &
  // WDATA_READY) transfers on the rising edge where both are high; RDATA_VALID
  // has no ready and must be taken in the cycle it is shown.
  always_comb begin
    state_nxt   = state_q;
    addr_nxt    = addr_q;
    cnt_nxt     = cnt_q;
    REQ_READY   = 1'b0;
    WDATA_READY = 1'b0;
    RAM_EN      = 1'b0;
    RAM_WE      = 1'b0;
    RAM_ADDR    = '0;
    RAM_DIN     = '0;
    wr_last     = 1'b0;
    case (state_q)
      IDLE: begin
        REQ_READY = !RST;
        if (REQ_VALID) begin
          addr_nxt  = REQ_ADDR;
          cnt_nxt   = REQ_LEN;
          state_nxt = REQ_WR ? WR : RD;
        end
      end
      WR: begin
        WDATA_READY = 1'b1;
        RAM_EN      = WDATA_VALID;
        RAM_WE      = WDATA_VALID;
        RAM_ADDR    = addr_q;
        RAM_DIN     = WDATA;
        if (WDATA_VALID) begin
          addr_nxt = addr_q + 1'b1;
          if (cnt_q == '0) begin
            wr_last   = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_q - 1'b1;
          end
        end
      end
      RD: begin
        RAM_EN   = 1'b1;
        RAM_ADDR = addr_q;
        // Last address is held so the drain cycle re-presents it.
        if (cnt_q == '0) begin
          state_nxt = RD_DRAIN;
        end else begin
          addr_nxt = addr_q + 1'b1;
          cnt_nxt  = cnt_q - 1'b1;
        end
      end
      RD_DRAIN: begin
        RAM_EN    = 1'b1;
        RAM_ADDR  = addr_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      rd_issued_q <= 1'b0;
      rd_last_q   <= 1'b0;
      RDATA       <= '0;
      RDATA_VALID <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      addr_q      <= addr_nxt;
      cnt_q       <= cnt_nxt;
      // RAM_DOUT is valid the cycle after an RD-state address.
      rd_issued_q <= (state_q == RD);
      rd_last_q   <= (state_q == RD) && (cnt_q == '0);
      RDATA_VALID <= rd_issued_q;
      if (rd_issued_q) RDATA <= RAM_DOUT;
      DONE        <= wr_last | rd_last_q;
    end
  end

  assign BUSY      = (state_q != IDLE);
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural RAM and a queue-based scoreboard
// checking read beats, RAM write/read addressing and DONE timing by cycle number.
module tb_ram_burst_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_VALID = 1'b0, REQ_READY, REQ_WR = 1'b0;
  logic [7:0] REQ_ADDR = '0;
  logic [3:0] REQ_LEN = '0;
  logic [9:0] WDATA = '0;
  logic       WDATA_VALID = 1'b0, WDATA_READY;
  logic [9:0] RDATA;
  logic       RDATA_VALID, DONE, BUSY, RAM_EN, RAM_WE;
  logic [7:0] RAM_ADDR;
  logic [9:0] RAM_DIN, RAM_DOUT;
  logic [1:0] STATE_DBG;

  ram_burst_ctrl dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .WDATA(WDATA), .WDATA_VALID(WDATA_VALID),
    .WDATA_READY(WDATA_READY), .RDATA(RDATA), .RDATA_VALID(RDATA_VALID), .DONE(DONE),
    .BUSY(BUSY), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN),
    .RAM_DOUT(RAM_DOUT), .STATE_DBG(STATE_DBG)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  logic [9:0] mem [256];
  logic [9:0] ram_q = '0;
  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
      else        ram_q <= mem[RAM_ADDR];
    end
  end
  assign RAM_DOUT = ram_q;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];
  int         exp_cyc_q[$];
  int         wr_cyc_q[$];
  logic [7:0] wr_addr_q[$];
  logic [9:0] wr_data_q[$];
  int         ra_cyc_q[$];
  logic [7:0] ra_addr_q[$];
  int         done_q[$];
  logic [9:0] shadow [256];
  logic [9:0] wbuf [16];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (RDATA_VALID) begin
      if (exp_q.size() == 0) check("rdata_unexpected", 1, 0);
      else begin
        check("rdata", int'(RDATA), int'(exp_q.pop_front()));
        check("rdata_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
    if (RAM_EN && RAM_WE) begin
      if (wr_cyc_q.size() == 0) check("ram_write_unexpected", 1, 0);
      else begin
        check("ram_write_addr", int'(RAM_ADDR), int'(wr_addr_q.pop_front()));
        check("ram_write_data", int'(RAM_DIN), int'(wr_data_q.pop_front()));
        check("ram_write_cycle", cyc, wr_cyc_q.pop_front());
      end
    end
    if (RAM_EN && !RAM_WE) begin
      if (ra_cyc_q.size() == 0) check("ram_read_unexpected", 1, 0);
      else begin
        check("ram_read_addr", int'(RAM_ADDR), int'(ra_addr_q.pop_front()));
        check("ram_read_cycle", cyc, ra_cyc_q.pop_front());
      end
    end
    if (DONE) begin
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else check("done_cycle", cyc, done_q.pop_front());
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic send_req(input logic wr, input logic [7:0] a, input logic [3:0] len,
                          output int h);
    int t = 0;
    REQ_WR = wr; REQ_ADDR = a; REQ_LEN = len; REQ_VALID = 1'b1;
    @(negedge CLK);
    while (!REQ_READY && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!REQ_READY) check("req_timeout", 0, 1);
    h = cyc;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; REQ_WR = 1'b0; REQ_ADDR = '0; REQ_LEN = '0;
  endtask

  task automatic push_write(input logic [7:0] a, input int n, input bit thr, input int h);
    int c = h + 1;
    for (int j = 0; j < n; j++) begin
      if (thr && j > 0) c++;
      wr_cyc_q.push_back(c);
      wr_addr_q.push_back(8'(a + j));
      wr_data_q.push_back(wbuf[j]);
      shadow[8'(a + j)] = wbuf[j];
      c++;
    end
    done_q.push_back(c);
  endtask

  task automatic drive_write(input int n, input bit thr);
    for (int j = 0; j < n; j++) begin
      if (thr && j > 0) begin
        WDATA_VALID = 1'b0; WDATA = '0;
        @(posedge CLK); #1;
      end
      WDATA_VALID = 1'b1; WDATA = wbuf[j];
      @(posedge CLK); #1;
    end
    WDATA_VALID = 1'b0; WDATA = '0;
  endtask

  task automatic push_read(input logic [7:0] a, input int len, input int h);
    for (int k = 0; k <= len; k++) begin
      exp_q.push_back(shadow[8'(a + k)]);
      exp_cyc_q.push_back(h + 3 + k);
      ra_cyc_q.push_back(h + 1 + k);
      ra_addr_q.push_back(8'(a + k));
    end
    ra_cyc_q.push_back(h + len + 2);
    ra_addr_q.push_back(8'(a + len));
    done_q.push_back(h + len + 3);
  endtask

  task automatic do_write(input logic [7:0] a, input int n, input bit thr, output int h);
    send_req(1'b1, a, 4'(n - 1), h);
    push_write(a, n, thr, h);
    drive_write(n, thr);
  endtask

  task automatic do_read(input logic [7:0] a, input int len, output int h);
    send_req(1'b0, a, 4'(len), h);
    push_read(a, len, h);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int h1, h2, t;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("rst_req_ready", int'(REQ_READY), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_ram_en", int'(RAM_EN), 0);
    check("rst_ram_we", int'(RAM_WE), 0);
    check("rst_rdata_valid", int'(RDATA_VALID), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_wdata_ready", int'(WDATA_READY), 0);
    check("rst_rdata", int'(RDATA), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_req_ready", int'(REQ_READY), 1);
    check("post_rst_state", int'(STATE_DBG), 0);
    @(posedge CLK); #1;

    // continuous write then back-to-back read
    wbuf[0] = 10'h001; wbuf[1] = 10'h002; wbuf[2] = 10'h003; wbuf[3] = 10'h004;
    do_write(8'h10, 4, 1'b0, h1);
    do_read(8'h10, 3, h2);
    check("b2b_handshake_gap", h2 - h1, 5);

    // throttled write, then readback
    wbuf[0] = 10'h0AA; wbuf[1] = 10'h0BB; wbuf[2] = 10'h0CC;
    do_write(8'h20, 3, 1'b1, h1);
    do_read(8'h20, 2, h2);

    // address wrap
    wbuf[0] = 10'h3FF; wbuf[1] = 10'h155; wbuf[2] = 10'h2AA; wbuf[3] = 10'h0F0;
    do_write(8'hFE, 4, 1'b0, h1);
    do_read(8'hFE, 3, h2);

    // single beat
    wbuf[0] = 10'h2A5;
    do_write(8'h40, 1, 1'b0, h1);
    do_read(8'h40, 0, h2);

    // reset in cycle 5 of a 16-beat read: beats 0..2 and addresses 1..5 only
    send_req(1'b0, 8'h10, 4'd15, h1);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(shadow[8'(8'h10 + k)]);
      exp_cyc_q.push_back(h1 + 3 + k);
    end
    for (int k = 0; k < 5; k++) begin
      ra_cyc_q.push_back(h1 + 1 + k);
      ra_addr_q.push_back(8'(8'h10 + k));
    end
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_busy", int'(BUSY), 0);
    check("midrst_ram_en", int'(RAM_EN), 0);
    check("midrst_rdata_valid", int'(RDATA_VALID), 0);
    check("midrst_done", int'(DONE), 0);
    check("midrst_rdata", int'(RDATA), 0);
    check("midrst_req_ready", int'(REQ_READY), 1);
    @(posedge CLK); #1;
    do_read(8'hFE, 3, h2);

    // busy hold-off: read request held valid during an 8-beat write
    for (int j = 0; j < 8; j++) wbuf[j] = 10'(10'h100 + j);
    send_req(1'b1, 8'h80, 4'd7, h1);
    push_write(8'h80, 8, 1'b0, h1);
    fork
      drive_write(8, 1'b0);
      send_req(1'b0, 8'h80, 4'd7, h2);
    join
    check("holdoff_handshake_gap", h2 - h1, 9);
    push_read(8'h80, 7, h2);

    // drain
    t = 0;
    while ((exp_q.size() != 0 || wr_cyc_q.size() != 0 || ra_cyc_q.size() != 0 ||
            done_q.size() != 0) && t < 200) begin
      @(negedge CLK);
      t++;
    end
    repeat (4) @(negedge CLK);
    check("left_rdata", exp_q.size(), 0);
    check("left_ram_write", wr_cyc_q.size(), 0);
    check("left_ram_read", ra_cyc_q.size(), 0);
    check("left_done", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
